// File: rtl/nx_ram_2rw_cfg.sv
// nx_ram_2rw_cfg: two-port (2RW) single-clock RAM with per-lane byte enables,
// configurable read latency, optional input registering, selectable
// cross-port collision behaviour and a hardware clear after reset.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   csa/wea/adda/dina/bwea        port A select, write/read, address, data, lane enables
//   csb/web/addb/dinb/bweb        port B, same meaning
//   douta/doutb                   read data, holds the last completed read
//   douta_vld/doutb_vld           one-cycle pulse when a read completes
//   init_done                     memory ready for user accesses
//   collision                     pulse one cycle after a same-address A+B write
//   drop                          pulse one cycle after an access ignored before ready
//
// state    | meaning
// RESET_ST | held in reset / first cycle after release
// INIT     | writing INIT_VALUE to address cnt_q, ascending
// READY    | user accesses accepted
module nx_ram_2rw_cfg #(
    parameter int              WIDTH          = 64,
    parameter int              BWEWIDTH       = 8,
    parameter int              DEPTH          = 256,
    parameter int              RD_LATENCY     = 1,
    parameter int              IN_FLOP        = 0,
    parameter int              COLLISION_MODE = 0,
    parameter int              INIT_ON_RESET  = 1,
    parameter logic [WIDTH-1:0] INIT_VALUE    = '0,
    localparam int             AW             = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                csa,
    input  logic                wea,
    input  logic [AW-1:0]       adda,
    input  logic [WIDTH-1:0]    dina,
    input  logic [BWEWIDTH-1:0] bwea,
    input  logic                csb,
    input  logic                web,
    input  logic [AW-1:0]       addb,
    input  logic [WIDTH-1:0]    dinb,
    input  logic [BWEWIDTH-1:0] bweb,
    output logic [WIDTH-1:0]    douta,
    output logic [WIDTH-1:0]    doutb,
    output logic                douta_vld,
    output logic                doutb_vld,
    output logic                init_done,
    output logic                collision,
    output logic                drop
);

    localparam int L = WIDTH / BWEWIDTH;

    localparam logic [1:0] RESET_ST = 2'd0;
    localparam logic [1:0] INIT     = 2'd1;
    localparam logic [1:0] READY    = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RESET_ST: begin
                state_d = (INIT_ON_RESET != 0) ? INIT : READY;
                cnt_d   = '0;
            end
            INIT: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == AW'(DEPTH - 1)) state_d = READY;
            end
            READY:   state_d = READY;
            default: state_d = RESET_ST;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESET_ST;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign init_done = (state_q == READY);

    // Effective access signals after the optional input stage. Acceptance is
    // decided when the request enters the block, so a flopped request that was
    // accepted stays accepted.
    logic                a_cs, a_we, b_cs, b_we;
    logic [AW-1:0]       a_add, b_add;
    logic [WIDTH-1:0]    a_din, b_din;
    logic [BWEWIDTH-1:0] a_bwe, b_bwe;

    generate
        if (IN_FLOP != 0) begin : g_in_flop
            logic                csa_q, wea_q, csb_q, web_q;
            logic [AW-1:0]       adda_q, addb_q;
            logic [WIDTH-1:0]    dina_q, dinb_q;
            logic [BWEWIDTH-1:0] bwea_q, bweb_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    csa_q  <= 1'b0;  csb_q  <= 1'b0;
                    wea_q  <= 1'b0;  web_q  <= 1'b0;
                    adda_q <= '0;    addb_q <= '0;
                    dina_q <= '0;    dinb_q <= '0;
                    bwea_q <= '0;    bweb_q <= '0;
                end else begin
                    csa_q  <= csa & init_done;  csb_q  <= csb & init_done;
                    wea_q  <= wea;   web_q  <= web;
                    adda_q <= adda;  addb_q <= addb;
                    dina_q <= dina;  dinb_q <= dinb;
                    bwea_q <= bwea;  bweb_q <= bweb;
                end
            end
            assign a_cs = csa_q & ~rst;  assign b_cs = csb_q & ~rst;
            assign a_we = wea_q;   assign b_we = web_q;
            assign a_add = adda_q; assign b_add = addb_q;
            assign a_din = dina_q; assign b_din = dinb_q;
            assign a_bwe = bwea_q; assign b_bwe = bweb_q;
        end else begin : g_no_flop
            assign a_cs = csa & init_done & ~rst;
            assign b_cs = csb & init_done & ~rst;
            assign a_we = wea;   assign b_we = web;
            assign a_add = adda; assign b_add = addb;
            assign a_din = dina; assign b_din = dinb;
            assign a_bwe = bwea; assign b_bwe = bweb;
        end
    endgenerate

    logic wr_a, wr_b, rd_a, rd_b;
    assign wr_a = a_cs & a_we;
    assign wr_b = b_cs & b_we;
    assign rd_a = a_cs & ~a_we;
    assign rd_b = b_cs & ~b_we;

    logic [WIDTH-1:0] mem_q [DEPTH];

    // B lanes are written first so that A's enabled lanes override on a
    // same-address write-write.
    always_ff @(posedge clk) begin
        if (!rst && state_q == INIT) mem_q[cnt_q] <= INIT_VALUE;
        for (int k = 0; k < BWEWIDTH; k++) begin
            if (wr_b && b_bwe[k]) mem_q[b_add][k*L +: L] <= b_din[k*L +: L];
        end
        for (int k = 0; k < BWEWIDTH; k++) begin
            if (wr_a && a_bwe[k]) mem_q[a_add][k*L +: L] <= a_din[k*L +: L];
        end
    end

    // Array read returns the pre-write word; write-through mode merges the
    // other port's enabled lanes on an address match.
    logic [WIDTH-1:0] rdat_a, rdat_b;
    always_comb begin
        rdat_a = mem_q[a_add];
        rdat_b = mem_q[b_add];
        if (COLLISION_MODE != 0) begin
            for (int k = 0; k < BWEWIDTH; k++) begin
                if (wr_b && b_bwe[k] && b_add == a_add) rdat_a[k*L +: L] = b_din[k*L +: L];
                if (wr_a && a_bwe[k] && a_add == b_add) rdat_b[k*L +: L] = a_din[k*L +: L];
            end
        end
    end

    // Each stage only loads on valid, so the last stage holds the last result.
    logic [RD_LATENCY-1:0] va_q, vb_q;
    logic [WIDTH-1:0]      da_q [RD_LATENCY];
    logic [WIDTH-1:0]      db_q [RD_LATENCY];

    always_ff @(posedge clk) begin
        if (rst) begin
            va_q <= '0;
            vb_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                da_q[i] <= '0;
                db_q[i] <= '0;
            end
        end else begin
            va_q[0] <= rd_a;
            vb_q[0] <= rd_b;
            if (rd_a) da_q[0] <= rdat_a;
            if (rd_b) db_q[0] <= rdat_b;
            for (int i = 1; i < RD_LATENCY; i++) begin
                va_q[i] <= va_q[i-1];
                vb_q[i] <= vb_q[i-1];
                if (va_q[i-1]) da_q[i] <= da_q[i-1];
                if (vb_q[i-1]) db_q[i] <= db_q[i-1];
            end
        end
    end

    assign douta     = da_q[RD_LATENCY-1];
    assign doutb     = db_q[RD_LATENCY-1];
    assign douta_vld = va_q[RD_LATENCY-1];
    assign doutb_vld = vb_q[RD_LATENCY-1];

    logic collision_q, drop_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            collision_q <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            collision_q <= wr_a & wr_b & (a_add == b_add);
            drop_q      <= (csa | csb) & ~init_done;
        end
    end

    assign collision = collision_q;
    assign drop      = drop_q;

endmodule

// File: doc/nx_ram_2rw_cfg.md
NX_RAM_2RW_CFG -- requirements
Module: nx_ram_2rw_cfg

Interface
REQ-001 SHALL have parameter WIDTH, default 64, data width in bits.
REQ-002 SHALL have parameter BWEWIDTH, default 8, write-enable lanes; WIDTH%BWEWIDTH==0, lane size L=WIDTH/BWEWIDTH.
REQ-003 SHALL have parameter DEPTH, default 256, entries; address width clog2(DEPTH), min 1.
REQ-004 SHALL have parameter RD_LATENCY, default 1, read pipeline stages, range 1..4.
REQ-005 SHALL have parameter IN_FLOP, default 0, 1 = register all port inputs (adds 1 cycle to every access).
REQ-006 SHALL have parameter COLLISION_MODE, default 0: 0 = cross-port read returns old data, 1 = write-through of the new data.
REQ-007 SHALL have parameter INIT_ON_RESET, default 1, 1 = hardware clear after reset.
REQ-008 SHALL have parameter INIT_VALUE, default 0, WIDTH-bit word written during clear.
REQ-009 Ports: clk  in  1  clock; one clock; reset is synchronous and active-high.
REQ-010 rst  in  1  synchronous active-high reset.
REQ-011 csa/csb  in  1  port A/B select; wea/web  in  1  write (1) / read (0).
REQ-012 adda/addb  in  clog2(DEPTH)  address; dina/dinb  in  WIDTH  write data; bwea/bweb  in  BWEWIDTH  lane enables.
REQ-013 douta/doutb  out  WIDTH  read data; douta_vld/doutb_vld  out  1  read-data valid pulse.
REQ-014 init_done  out  1  memory ready; collision  out  1  write-write same-address pulse; drop  out  1  access ignored during init.

Function
REQ-015 Write: lane k of mem[add] SHALL take din[k*L+:L] only where bwe[k]=1; other lanes keep old value.
REQ-016 Read issued at cycle T (cs=1, we=0, init_done=1) SHALL present dout with dout_vld=1 in exactly cycle T+RD_LATENCY+IN_FLOP, vld one cycle wide.
REQ-017 dout SHALL hold the last read value until the next read completes; writes never change dout or assert vld.
REQ-018 Back-to-back reads every cycle SHALL return one result per cycle, in order, no bubbles.
REQ-019 Both ports SHALL operate independently and concurrently on different addresses.
REQ-020 Same-address A write + B read, same cycle: COLLISION_MODE=0 -> B returns pre-write word; 1 -> B returns merged new word; symmetric for B write + A read.
REQ-021 Same-address A write + B write, same cycle: per lane, A's enabled lanes win, B's lanes win only where bwea=0; collision=1 one cycle later.
REQ-022 Same-address read on both ports SHALL return identical data on both, no collision.
REQ-023 FSM states RESET_ST, INIT, READY: rst -> RESET_ST; RESET_ST -> INIT if INIT_ON_RESET else READY, next cycle.
REQ-024 INIT SHALL write INIT_VALUE to addresses 0..DEPTH-1, one per cycle in ascending order, via counter; after address DEPTH-1 go READY.
REQ-025 init_done SHALL be 1 only in READY; first user access accepted the cycle init_done is 1.
REQ-026 Any cs=1 while init_done=0 SHALL be ignored (no write, no vld) and pulse drop=1 one cycle later.
REQ-027 With INIT_ON_RESET=0, contents SHALL be unchanged by reset; init_done=1 from the second cycle after rst deasserts.

Reset
REQ-028 While rst=1: douta, doutb=0; douta_vld, doutb_vld, collision, drop, init_done=0; read pipelines and input flops flushed.
REQ-029 rst asserted mid-INIT SHALL restart clearing from address 0 after release; in-flight reads SHALL be discarded, never emit vld.
REQ-030 Total clear time SHALL be DEPTH+1 cycles from rst deassertion to init_done=1.

Verification (WIDTH=32, BWEWIDTH=4, DEPTH=16, RD_LATENCY=2, IN_FLOP=0, INIT_VALUE=0xDEADBEEF)
REQ-031 Release rst -> init_done rises exactly 17 cycles later; read addr 15 -> 0xDEADBEEF, vld 2 cycles after issue.
REQ-032 A writes 0x11223344 bwe=4'b0101 to addr 3 -> B read addr 3 returns 0xDE22BE44.
REQ-033 Same cycle A write 0xAAAAAAAA bwe=4'hF, B read addr 5: mode 0 -> B gets 0xDEADBEEF; mode 1 -> 0xAAAAAAAA.
REQ-034 Same cycle A write 0x000000FF bwe=4'b0001, B write 0xFFFFFF00 bwe=4'hF, addr 7 -> mem[7]=0xFFFFFFFF, collision pulse next cycle.
REQ-035 csa=1 on cycle 5 after release -> drop pulses, mem unchanged; rst at cycle 8 -> init restarts, init_done 17 cycles after second release.
REQ-036 16 back-to-back reads on A, addr 0..15 -> 16 consecutive vld cycles, data in address order.
